seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Sequential unsigned restoring divider that inverts the add/subtract datapath. It recovers quotient and remainder from a dividend and divisor by repeated shift-and-subtract, one quotient bit per clock. It is built from the same ripple add/sub primitive, used in subtract mode, and sits beside the adder/subtractor as the arithmetic unit's divide path. A start/busy/done handshake controls it.

Parameters:
W, 4, operand width in bits (dividend, divisor, quotient, remainder); legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse or level; sampled only in IDLE or DONE
dividend  input  W  unsigned dividend; captured on the accepting edge
divisor  input  W  unsigned divisor; captured on the accepting edge
quotient  output  W  registered quotient; valid when done=1, held until the next completion
remainder  output  W  registered remainder; valid when done=1, held until the next completion
busy  output  1  high while in RUN
done  output  1  single-cycle completion pulse (high only in DONE)
div_by_zero  output  1  registered flag; qualifies the current result, updated with quotient

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE.
  - quotient=0, remainder=0, busy=0, done=0, div_by_zero=0.
  - Internal R, Q, divisor register and count are cleared.
  - Reset asserted mid-RUN aborts the operation with no done pulse; outputs take their reset values immediately.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at a rising edge (accept edge):
  - divisor!=0: latch D=divisor, Q=dividend, R=0 (W+1 bits), count=0; go to RUN; busy=1 after that edge.
  - divisor==0: go to DONE directly. quotient=all ones, remainder=dividend, div_by_zero=1, done=1 after the accept edge (latency 1).
- IDLE with start=0: stay. DONE with start=0: go to IDLE and done falls.
- RUN, each edge does one iteration:
  - {R,Q} shifted left 1.
  - T = R_shifted - {0,D}, computed over W+1 bits as add/sub with subtract mode: B inverted, carry-in 1.
  - If T MSB=0: R=T and Q[0]=1. Otherwise R is kept (restore) and Q[0]=0.
  - count increments.
- RUN exit: on the edge where count==W-1 (the W-th iteration), go to DONE.
  - quotient and remainder are loaded from the post-iteration Q and R[W-1:0]; div_by_zero=0.
  - done=1 and busy=0 after that edge.
- Latency (divisor!=0): start accepted at edge 0 gives done=1 after edge W. For W=4, done is visible in the cycle after edge 4.
- start while in RUN is ignored. Operands changing during RUN have no effect.
- Back-to-back: start=1 during DONE is accepted. done falls and busy rises after that edge, giving one done cycle per operation.
- Invariants when done=1 and div_by_zero=0:
  - dividend == quotient*divisor + remainder.
  - remainder < divisor.
- No overflow is possible for unsigned W/W division. The quotient always fits in W bits.

Test Plan:
1. rst_n=0 then 1; dividend=13, divisor=3, start pulse at edge 0 -> busy=1 for edges 1..3, done=1 after edge 4, quotient=4, remainder=1, div_by_zero=0.
2. 15/1 -> quotient=15, remainder=0. 3/9 -> quotient=0, remainder=3. 0/5 -> quotient=0, remainder=0. Each completes in exactly W cycles.
3. dividend=7, divisor=0, start -> done=1 after the accept edge, quotient=4'hF, remainder=7, div_by_zero=1, busy never asserted.
4. Start 12/5, pull rst_n low mid-RUN (after edge 2, asynchronously) -> outputs 0 immediately, no done pulse. Release, start 9/2 -> quotient=4, remainder=1.
5. Start 14/4; pulse start with 1/1 at edge 2 during RUN -> ignored, result quotient=3, remainder=2.
6. Back-to-back: hold start=1 with 10/3 then 8/2 -> done one cycle with 3/1, next done with 4/0. Exhaustive sweep of all 16x15 nonzero-divisor pairs checked against the divide/modulo invariants.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: sequential unsigned restoring divider, one quotient bit per clock.
// The trial subtraction reuses a ripple add/sub primitive driven in subtract
// mode (B inverted, carry-in 1). A start/busy/done handshake sequences work.
module seq_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Ripple-carry add/sub over W+1 bits; sub=1 inverts b and injects carry-in 1.
  function automatic logic [W:0] addsub(input logic [W:0] a,
                                        input logic [W:0] b,
                                        input logic       sub);
    logic [W:0] bb;
    logic [W:0] s;
    logic       c;
    bb = sub ? ~b : b;
    c  = sub;
    for (int i = 0; i <= W; i++) begin
      s[i] = a[i] ^ bb[i] ^ c;
      c    = (a[i] & bb[i]) | (c & (a[i] ^ bb[i]));
    end
    return s;
  endfunction

  state_t           state_q;
  logic [W:0]       r_q;
  logic [W-1:0]     q_q;
  logic [W-1:0]     d_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     quotient_q;
  logic [W-1:0]     remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [W:0]       r_shift;
  logic [W:0]       trial;
  logic [W:0]       r_d;
  logic [W-1:0]     q_d;

  // One restoring iteration: shift {R,Q} left, trial-subtract D, restore on borrow.
  always_comb begin
    r_shift = {r_q[W-1:0], q_q[W-1]};
    trial   = addsub(r_shift, {1'b0, d_q}, 1'b1);
    r_d     = r_shift;
    q_d     = {q_q[W-2:0], 1'b0};
    if (!trial[W]) begin
      r_d    = trial;
      q_d[0] = 1'b1;
    end
  end

  // Control FSM with registered outputs and iteration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor != '0) begin
              d_q     <= divisor;
              q_q     <= dividend;
              r_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              // Divide by zero completes immediately with a flagged result.
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_DONE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[W-1:0];
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed testbench for seq_divider (W=4) with immediate-assertion checks.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int compared;
  int mismatched;

  seq_divider #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE: accept, W iterations, DONE, back to IDLE.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input string tag);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    edge1();
    start = 1'b0;
    for (int i = 0; i < W - 1; i++) begin
      chk($sformatf("%s busy@%0d", tag, i + 1), {31'd0, busy}, 32'd1);
      chk($sformatf("%s nodone@%0d", tag, i + 1), {31'd0, done}, 32'd0);
      edge1();
    end
    chk({tag, " busy_last"}, {31'd0, busy}, 32'd1);
    edge1();
    chk({tag, " done"}, {31'd0, done}, 32'd1);
    chk({tag, " busy_off"}, {31'd0, busy}, 32'd0);
    chk({tag, " quot"}, {28'd0, quotient}, {28'd0, eq});
    chk({tag, " rem"}, {28'd0, remainder}, {28'd0, er});
    chk({tag, " dbz"}, {31'd0, div_by_zero}, 32'd0);
    edge1();
    chk({tag, " done_fall"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    #2;
    edge1();
    chk("rst quot", {28'd0, quotient}, 32'd0);
    chk("rst rem", {28'd0, remainder}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    edge1();

    // 1. 13/3
    run_div(4'd13, 4'd3, 4'd4, 4'd1, "t1 13/3");

    // 2. assorted
    run_div(4'd15, 4'd1, 4'd15, 4'd0, "t2 15/1");
    run_div(4'd3, 4'd9, 4'd0, 4'd3, "t2 3/9");
    run_div(4'd0, 4'd5, 4'd0, 4'd0, "t2 0/5");

    // 3. divide by zero
    dividend = 4'd7;
    divisor  = 4'd0;
    start    = 1'b1;
    edge1();
    start = 1'b0;
    chk("t3 done", {31'd0, done}, 32'd1);
    chk("t3 busy", {31'd0, busy}, 32'd0);
    chk("t3 quot", {28'd0, quotient}, 32'd15);
    chk("t3 rem", {28'd0, remainder}, 32'd7);
    chk("t3 dbz", {31'd0, div_by_zero}, 32'd1);
    edge1();
    chk("t3 done_fall", {31'd0, done}, 32'd0);
    chk("t3 busy_idle", {31'd0, busy}, 32'd0);
    chk("t3 quot_hold", {28'd0, quotient}, 32'd15);

    // 4. async reset mid-RUN
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    edge1();
    chk("t4 busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4 rst busy", {31'd0, busy}, 32'd0);
    chk("t4 rst done", {31'd0, done}, 32'd0);
    chk("t4 rst quot", {28'd0, quotient}, 32'd0);
    chk("t4 rst rem", {28'd0, remainder}, 32'd0);
    chk("t4 rst dbz", {31'd0, div_by_zero}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk($sformatf("t4 no_done@%0d", i), {31'd0, done}, 32'd0);
    end
    #2 rst_n = 1'b1;
    edge1();
    run_div(4'd9, 4'd2, 4'd4, 4'd1, "t4 9/2");

    // 5. start during RUN is ignored
    dividend = 4'd14;
    divisor  = 4'd4;
    start    = 1'b1;
    edge1();
    start = 1'b0;
    edge1();
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    edge1();
    start = 1'b0;
    edge1();
    chk("t5 busy", {31'd0, busy}, 32'd1);
    edge1();
    chk("t5 done", {31'd0, done}, 32'd1);
    chk("t5 quot", {28'd0, quotient}, 32'd3);
    chk("t5 rem", {28'd0, remainder}, 32'd2);
    edge1();
    chk("t5 done_fall", {31'd0, done}, 32'd0);

    // 6. back-to-back with start held
    dividend = 4'd10;
    divisor  = 4'd3;
    start    = 1'b1;
    edge1();
    dividend = 4'd8;
    divisor  = 4'd2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t6a busy@%0d", i + 1), {31'd0, busy}, 32'd1);
      edge1();
    end
    edge1();
    chk("t6a done", {31'd0, done}, 32'd1);
    chk("t6a quot", {28'd0, quotient}, 32'd3);
    chk("t6a rem", {28'd0, remainder}, 32'd1);
    edge1();
    start = 1'b0;
    chk("t6b done_fall", {31'd0, done}, 32'd0);
    chk("t6b busy", {31'd0, busy}, 32'd1);
    edge1();
    edge1();
    edge1();
    chk("t6b nodone", {31'd0, done}, 32'd0);
    edge1();
    chk("t6b done", {31'd0, done}, 32'd1);
    chk("t6b quot", {28'd0, quotient}, 32'd4);
    chk("t6b rem", {28'd0, remainder}, 32'd0);
    edge1();
    chk("t6b done_fall", {31'd0, done}, 32'd0);

    // Sweep all nonzero-divisor pairs with invariant checks.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_div(W'(a), W'(b), W'(a / b), W'(a % b), $sformatf("sw %0d/%0d", a, b));
        chk($sformatf("sw inv %0d/%0d", a, b),
            32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        chk($sformatf("sw rlt %0d/%0d", a, b),
            {31'd0, (32'(remainder) < 32'(b))}, 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
